// File: rtl/stop_watch_pkg.sv
// Shared constants for the stop_watch display path: digit count and
// active-high 7-segment patterns ordered {g,f,e,d,c,b,a}.
package stop_watch_pkg;
  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/stop_watch_display_if.sv
// Bundle between the stop_watch time source / board pins and the display driver.
interface stop_watch_display_if;
  logic       enable;
  logic [3:0] sec_lsb;
  logic [3:0] sec_msb;
  logic [3:0] min_lsb;
  logic [3:0] min_msb;
  logic [3:0] hr_lsb;
  logic [3:0] hr_msb;
  logic [5:0] dp_mask;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [5:0] an_out;
  logic       frame_tick;

  modport master (
    output enable, sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb, dp_mask,
    input  seg_out, dp_out, an_out, frame_tick
  );

  modport slave (
    input  enable, sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb, dp_mask,
    output seg_out, dp_out, an_out, frame_tick
  );
endinterface

// File: rtl/stop_watch_seg_dec.sv
// BCD digit to active-high 7-segment pattern; non-BCD codes show a dash.
module stop_watch_seg_dec
  import stop_watch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Codes 10-15 are an error indicator and must stay visible
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stop_watch_display.sv
// Six-digit multiplexed 7-segment driver; digits are snapshotted once per scan
// frame so one frame never mixes two time values.
module stop_watch_display
  import stop_watch_pkg::*;
#(
  parameter int DIV      = 1000,
  parameter int SEG_AL   = 1,
  parameter int AN_AL    = 1,
  parameter int LZ_BLANK = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  stop_watch_display_if.slave  io_disp
);

  localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF    = (SEG_AL != 0) ? 7'h7F : 7'h00;
  localparam logic             DP_OFF     = (SEG_AL != 0) ? 1'b1 : 1'b0;
  localparam logic [5:0]       AN_OFF     = (AN_AL != 0) ? 6'h3F : 6'h00;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [3:0]    r_dig [NUM_DIGITS];
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [5:0]    r_an;
  logic          r_tick;

  logic          w_last;
  logic          w_snap;
  logic [3:0]    w_digit;
  logic          w_dp;
  logic [6:0]    w_dec;
  logic [6:0]    w_seg_hi;
  logic [5:0]    w_an_hi;

  assign w_last  = (r_presc == PRESC_LAST);
  assign w_snap  = io_disp.enable && w_last && (r_idx == IDX_LAST);
  assign w_an_hi = 6'd1 << r_idx;

  // Prescaler and digit index advance only while scanning is enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else if (io_disp.enable) begin
      if (w_last) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Shadow digits load together on the edge that wraps idx back to 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (w_snap) begin
      r_dig[0] <= io_disp.sec_lsb;
      r_dig[1] <= io_disp.sec_msb;
      r_dig[2] <= io_disp.min_lsb;
      r_dig[3] <= io_disp.min_msb;
      r_dig[4] <= io_disp.hr_lsb;
      r_dig[5] <= io_disp.hr_msb;
    end
  end

  // Current digit and its live decimal-point request
  always_comb begin
    w_digit = 4'd0;
    w_dp    = 1'b0;
    case (r_idx)
      3'd0:    begin w_digit = r_dig[0]; w_dp = io_disp.dp_mask[0]; end
      3'd1:    begin w_digit = r_dig[1]; w_dp = io_disp.dp_mask[1]; end
      3'd2:    begin w_digit = r_dig[2]; w_dp = io_disp.dp_mask[2]; end
      3'd3:    begin w_digit = r_dig[3]; w_dp = io_disp.dp_mask[3]; end
      3'd4:    begin w_digit = r_dig[4]; w_dp = io_disp.dp_mask[4]; end
      3'd5:    begin w_digit = r_dig[5]; w_dp = io_disp.dp_mask[5]; end
      default: begin w_digit = 4'd0;     w_dp = 1'b0;               end
    endcase
  end

  stop_watch_seg_dec u_seg_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  // Leading-zero blanking only touches segments; anode and dp keep working
  always_comb begin
    w_seg_hi = w_dec;
    if ((LZ_BLANK != 0) && (r_idx == IDX_LAST) && (w_digit == 4'd0)) begin
      w_seg_hi = SEG_BLANK;
    end else begin
      w_seg_hi = w_dec;
    end
  end

  // Registered pin drive with polarity applied; disabled scan goes dark
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an   <= AN_OFF;
      r_seg  <= SEG_OFF;
      r_dp   <= DP_OFF;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_snap;
      if (io_disp.enable) begin
        r_an  <= (AN_AL != 0)  ? ~w_an_hi  : w_an_hi;
        r_seg <= (SEG_AL != 0) ? ~w_seg_hi : w_seg_hi;
        r_dp  <= (SEG_AL != 0) ? ~w_dp     : w_dp;
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
      end
    end
  end

  assign io_disp.an_out     = r_an;
  assign io_disp.seg_out    = r_seg;
  assign io_disp.dp_out     = r_dp;
  assign io_disp.frame_tick = r_tick;

endmodule
